regfile_bypass_sb: RTL

- Parametrised successor to the 32x32 two-read/one-write pipeline register file.
- Adds configurable width and depth, a hardwired-zero register mode, and same-cycle write-to-read bypass.
- Adds a read-enable hold for pipeline stalls and a pending-write scoreboard with busy flags and a pending count.
- Sits in the decode stage: read addresses come from the decoder, the write port is driven from pipe stage 4 (writeback), and issue marks come from the decode/issue logic.

---
 rtl/regfile_bypass_sb_if.sv | 29 ++
 rtl/regfile_bypass_sb.sv | 90 +++++++++
 2 files changed

// File: rtl/regfile_bypass_sb_if.sv
// Decode-stage register file bus: read ports, writeback port, issue marks and scoreboard status.
interface regfile_bypass_sb_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic              RD_EN;
   logic [ADDR_W-1:0] RA1;
   logic [ADDR_W-1:0] RA2;
   logic              RegWrite;
   logic [ADDR_W-1:0] WN;
   logic [DATA_W-1:0] WD;
   logic              ISSUE_EN;
   logic [ADDR_W-1:0] ISSUE_WN;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;
   logic              BUSY1;
   logic              BUSY2;
   logic [ADDR_W:0]   PEND_CNT;

   modport master (
      output RD_EN, RA1, RA2, RegWrite, WN, WD, ISSUE_EN, ISSUE_WN,
      input  RD1, RD2, BUSY1, BUSY2, PEND_CNT
   );

   modport slave (
      input  RD_EN, RA1, RA2, RegWrite, WN, WD, ISSUE_EN, ISSUE_WN,
      output RD1, RD2, BUSY1, BUSY2, PEND_CNT
   );
endinterface

// File: rtl/regfile_bypass_sb.sv
// Two-read/one-write register file with writeback bypass, stall hold and a pending-write scoreboard.
module regfile_bypass_sb #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 5,
   parameter bit          ZERO_REG   = 1'b1,
   parameter bit          INIT_INDEX = 1'b1
) (
   input logic                CLOCK,
   input logic                RESET,
   regfile_bypass_sb_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   function automatic logic [DEPTH-1:0][DATA_W-1:0] init_table();
      init_table = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         init_table[ADDR_W'(i)] = INIT_INDEX ? DATA_W'(i) : '0;
      end
   endfunction

   localparam logic [DEPTH-1:0][DATA_W-1:0] MEM_INIT = init_table();

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DEPTH-1:0]             pend_q;
   logic [DEPTH-1:0]             pend_next;
   logic [CNT_W-1:0]             cnt_q;
   logic [CNT_W-1:0]             cnt_next;
   logic [DATA_W-1:0]            rd1_q, rd2_q;
   logic [DATA_W-1:0]            rd1_next, rd2_next;
   logic                         busy1_q, busy2_q;
   logic                         weff;

   assign weff = bus.RegWrite && !(ZERO_REG && (bus.WN == '0));

   // Read mux: hardwired zero beats the writeback bypass, which beats storage.
   always_comb begin
      rd1_next = mem[bus.RA1];
      rd2_next = mem[bus.RA2];
      if (weff && (bus.WN == bus.RA1)) rd1_next = bus.WD;
      if (weff && (bus.WN == bus.RA2)) rd2_next = bus.WD;
      if (ZERO_REG && (bus.RA1 == '0)) rd1_next = '0;
      if (ZERO_REG && (bus.RA2 == '0)) rd2_next = '0;
   end

   // A new issue supersedes a same-cycle writeback of the older producer.
   always_comb begin
      pend_next = '0;
      for (int unsigned r = 0; r < DEPTH; r++) begin
         pend_next[ADDR_W'(r)] = (bus.ISSUE_EN && (bus.ISSUE_WN == ADDR_W'(r))) ||
                                 (pend_q[ADDR_W'(r)] && !(bus.RegWrite && (bus.WN == ADDR_W'(r))));
      end
      if (ZERO_REG) pend_next[0] = 1'b0;
      cnt_next = CNT_W'($countones(pend_next));
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         mem <= MEM_INIT;
      end else if (weff) begin
         mem[bus.WN] <= bus.WD;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rd1_q   <= '0;
         rd2_q   <= '0;
         busy1_q <= 1'b0;
         busy2_q <= 1'b0;
         pend_q  <= '0;
         cnt_q   <= '0;
      end else begin
         pend_q <= pend_next;
         cnt_q  <= cnt_next;
         if (bus.RD_EN) begin
            rd1_q   <= rd1_next;
            rd2_q   <= rd2_next;
            busy1_q <= pend_next[bus.RA1];
            busy2_q <= pend_next[bus.RA2];
         end
      end
   end

   assign bus.RD1      = rd1_q;
   assign bus.RD2      = rd2_q;
   assign bus.BUSY1    = busy1_q;
   assign bus.BUSY2    = busy2_q;
   assign bus.PEND_CNT = cnt_q;
endmodule
